dmem_interface: RTL and testbench

Memory-stage data-side interface between the pipelined core's memory stage and a single-port data memory with a req/ack handshake. It converts the M-stage address, store data, size and sign information into a word-aligned bus request with byte enables. It runs a small FSM that stalls the pipeline until the memory acknowledges. It then returns lane-aligned, sign- or zero-extended load data as ReadDataM for the writeback register.

---
 rtl/dmem_pkg.sv | 33 +++
 rtl/dmem_interface_extract.sv | 29 ++
 rtl/dmem_interface.sv | 118 +++++++++++
 tb/tb_dmem_interface.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory interface: size codes, FSM states
// and the byte-enable / alignment helpers used by the store path.
`timescale 1ns/1ps
package dmem_pkg;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } dmem_state_t;

  function automatic logic [3:0] be_for(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: be_for = 4'b0001 << lane;
      SZ_HALF: be_for = lane[1] ? 4'b1100 : 4'b0011;
      default: be_for = 4'b1111;
    endcase
  endfunction

  // Reserved size 11 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: is_misaligned = 1'b0;
      SZ_HALF: is_misaligned = lane[0];
      default: is_misaligned = |lane;
    endcase
  endfunction

endpackage

// File: rtl/dmem_interface_extract.sv
// Load-data lane extractor: picks the addressed byte/halfword out of a bus
// word and zero- or sign-extends it to 32 bits. Purely combinational.
`timescale 1ns/1ps
module mem_lane_extract
  import dmem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  output logic [31:0] result
);

  logic [31:0] shifted;
  logic [7:0]  byte_val;
  logic [15:0] half_val;

  always_comb begin
    shifted  = rdata >> {lane, 3'b000};
    byte_val = shifted[7:0];
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_BYTE: result = {{24{sign_ext & byte_val[7]}}, byte_val};
      SZ_HALF: result = {{16{sign_ext & half_val[15]}}, half_val};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/dmem_interface.sv
// M-stage data-memory interface: formats the request, stalls the pipeline
// through a registered req/ack bus access and returns extended load data.
`timescale 1ns/1ps
module dmem_interface
  import dmem_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemReqM,
  input  logic          MemWriteM,
  input  logic [1:0]    SizeM,
  input  logic          SignedM,
  input  logic [AW-1:0] ALUOutM,
  input  logic [DW-1:0] WriteDataM,
  output logic [DW-1:0] ReadDataM,
  output logic          StallMemM,
  output logic          MisalignM,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [3:0]    mem_be,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output dmem_state_t   dbg_state
);

  // Bus handshake: mem_req rises when ACCESS is entered and holds, together
  // with addr/we/be/wdata, until the cycle in which mem_ack is seen high;
  // that cycle completes the transfer and mem_rdata is valid only then.

  dmem_state_t state, state_next;
  logic [1:0]  lane_in;
  logic        misaligned;
  logic        start;
  logic [DW-1:0] wdata_fmt;
  logic [DW-1:0] extracted;
  logic [DW-1:0] hold;
  logic [1:0]  req_lane;
  logic [1:0]  req_size;
  logic        req_sign;

  assign dbg_state  = state;
  assign lane_in    = ALUOutM[1:0];
  assign misaligned = is_misaligned(SizeM, lane_in);
  assign start      = (state == IDLE) && MemReqM && !misaligned;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = ACCESS;
      ACCESS:  if (mem_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset gating keeps the stall and abort outputs quiet while reset is held.
  always_comb begin
    StallMemM = reset && (start || (state == ACCESS));
    MisalignM = reset && (state == IDLE) && MemReqM && misaligned;
    ReadDataM = (state == DONE) ? hold : '0;
  end

  always_comb begin
    case (SizeM)
      SZ_BYTE: wdata_fmt = {4{WriteDataM[7:0]}};
      SZ_HALF: wdata_fmt = {2{WriteDataM[15:0]}};
      default: wdata_fmt = WriteDataM;
    endcase
  end

  mem_lane_extract u_extract (
    .rdata    (mem_rdata),
    .lane     (req_lane),
    .size     (req_size),
    .sign_ext (req_sign),
    .result   (extracted)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= 4'b0000;
      mem_wdata <= '0;
      hold      <= '0;
      req_lane  <= 2'b00;
      req_size  <= SZ_WORD;
      req_sign  <= 1'b0;
    end else begin
      if (start) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUOutM[AW-1:2], 2'b00};
        mem_be    <= be_for(SizeM, lane_in);
        mem_wdata <= wdata_fmt;
        req_lane  <= lane_in;
        req_size  <= SizeM;
        req_sign  <= SignedM;
      end
      if ((state == ACCESS) && mem_ack) begin
        mem_req <= 1'b0;
        if (!mem_we) hold <= extracted;
      end
    end
  end

endmodule

// File: tb/tb_dmem_interface.sv
// Self-checking bench for dmem_interface: directed cases followed by random
// accesses against a byte-addressed memory model.
`timescale 1ns/1ps
module tb_dmem_interface;
  import dmem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReqM, MemWriteM, SignedM;
  logic [1:0]  SizeM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallMemM, MisalignM;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;
  dmem_state_t dbg_state;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_model [0:63];
  logic [31:0] last_load;

  always #5 clk = ~clk;

  dmem_interface #(.AW(32), .DW(32)) dut (
    .clk(clk), .reset(reset), .MemReqM(MemReqM), .MemWriteM(MemWriteM),
    .SizeM(SizeM), .SignedM(SignedM), .ALUOutM(ALUOutM), .WriteDataM(WriteDataM),
    .ReadDataM(ReadDataM), .StallMemM(StallMemM), .MisalignM(MisalignM),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int size_len(input logic [1:0] sz);
    return (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  // Byte enables = set of byte addresses covered by the access within its word.
  function automatic logic [3:0] model_be(input logic [31:0] addr, input logic [1:0] sz);
    int first = addr % 4;
    logic [3:0] be = 4'b0000;
    for (int k = first; k < first + size_len(sz); k++) be[k] = 1'b1;
    return be;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] wd, input logic [1:0] sz);
    int len = size_len(sz);
    longint unsigned value = longint'(wd) % (64'd1 << (8 * len));
    longint unsigned r = 0;
    for (int k = 0; k < 4 / len; k++) r = r | (value << (8 * len * k));
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] addr,
                                             input logic [1:0] sz, input logic sgn);
    int len = size_len(sz);
    longint v;
    if (len == 4) return rd;
    v = (longint'(rd) >> (8 * (addr % 4))) % (64'sd1 << (8 * len));
    if (sgn && v >= (64'sd1 << (8 * len - 1))) v = v - (64'sd1 << (8 * len));
    return v[31:0];
  endfunction

  task automatic do_access(input logic [31:0] addr, input logic we, input logic [1:0] sz,
                           input logic sgn, input logic [31:0] wd, input int waits,
                           input logic [31:0] rdata);
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd;
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = we; SizeM = sz; SignedM = sgn;
    ALUOutM = addr; WriteDataM = wd; mem_ack = 1'b0; mem_rdata = $urandom;
    #1;
    if ((addr % size_len(sz)) != 0) begin
      check("misalign_pulse", MisalignM, 1);
      check("misalign_stall", StallMemM, 0);
      check("misalign_req", mem_req, 0);
      check("misalign_rdata", ReadDataM, 0);
      @(posedge clk); #1;
      MemReqM = 1'b0;
      #1;
      check("misalign_one_cycle", MisalignM, 0);
      check("misalign_req_after", mem_req, 0);
      check("misalign_state", dbg_state, IDLE);
      return;
    end
    check("start_stall", StallMemM, 1);
    check("start_misalign", MisalignM, 0);
    e_be = model_be(addr, sz);
    e_wd = model_wdata(wd, sz);
    if (!we) exp_q.push_back(model_load(rdata, addr, sz, sgn));
    for (int i = 0; i <= waits; i++) begin
      @(posedge clk); #1;
      mem_ack   = (i == waits);
      mem_rdata = mem_ack ? rdata : $urandom;
      #1;
      check("acc_req", mem_req, 1);
      check("acc_stall", StallMemM, 1);
      check("acc_addr", mem_addr, addr & 32'hFFFF_FFFC);
      check("acc_be", mem_be, e_be);
      check("acc_we", mem_we, we);
      if (we) check("acc_wdata", mem_wdata, e_wd);
    end
    @(posedge clk); #1;
    mem_ack   = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    #1;
    check("done_state", dbg_state, DONE);
    check("done_stall", StallMemM, 0);
    check("done_req", mem_req, 0);
    if (!we) begin
      e_rd = exp_q.pop_front();
      last_load = e_rd;
    end else begin
      e_rd = last_load;
      for (int k = 0; k < 4; k++)
        if (e_be[k]) mem_model[addr[7:2]][8*k +: 8] = e_wd[8*k +: 8];
    end
    check("done_rdata", ReadDataM, e_rd);
  endtask

  initial begin
    logic [31:0] addr;
    logic [1:0]  sz;
    logic        we;
    for (int i = 0; i < 64; i++) mem_model[i] = $urandom;
    last_load = 32'h0;
    reset = 1'b0; MemReqM = 1'b1; MemWriteM = 1'b0; SizeM = SZ_WORD; SignedM = 1'b0;
    ALUOutM = 32'h40; WriteDataM = 32'h1234_5678; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", dbg_state, IDLE);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_be", mem_be, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rdata", ReadDataM, 0);
    check("rst_stall", StallMemM, 0);
    check("rst_misalign", MisalignM, 0);
    reset = 1'b1; MemReqM = 1'b0; mem_ack = 1'b0;

    do_access(32'h100, 1'b1, SZ_WORD, 1'b0, 32'hDEAD_BEEF, 2, 32'h0);
    do_access(32'h203, 1'b0, SZ_BYTE, 1'b1, 32'h0, 0, 32'h80FF_1234);
    check("sbyte_value", last_load, 32'hFFFF_FF80);
    do_access(32'h302, 1'b0, SZ_HALF, 1'b0, 32'h0, 1, 32'hABCD_0000);
    check("uhalf_value", last_load, 32'h0000_ABCD);
    do_access(32'h302, 1'b0, SZ_HALF, 1'b1, 32'h0, 0, 32'hABCD_0000);
    check("shalf_value", last_load, 32'hFFFF_ABCD);
    do_access(32'h401, 1'b1, SZ_BYTE, 1'b0, 32'h0000_00A5, 0, 32'h0);
    do_access(32'h502, 1'b0, SZ_WORD, 1'b0, 32'h0, 0, 32'h0);
    do_access(32'h505, 1'b1, SZ_HALF, 1'b0, 32'h0, 0, 32'h0);
    do_access(32'h507, 1'b0, 2'b11, 1'b1, 32'h0, 0, 32'h0);

    // Reset while the bus access is outstanding; the late ack must be dropped.
    do_access(32'h600, 1'b0, SZ_HALF, 1'b0, 32'h0, 0, 32'h1111_2222);
    @(posedge clk); #1;
    MemReqM = 1'b1; MemWriteM = 1'b0; SizeM = SZ_WORD; ALUOutM = 32'h600; mem_ack = 1'b0;
    #1;
    check("rst_mid_start_stall", StallMemM, 1);
    @(posedge clk); #1;
    check("rst_mid_access_req", mem_req, 1);
    reset = 1'b0; MemReqM = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_mid_state", dbg_state, IDLE);
    check("rst_mid_req", mem_req, 0);
    check("rst_mid_stall", StallMemM, 0);
    check("rst_mid_rdata", ReadDataM, 0);
    @(posedge clk); #1;
    mem_ack = 1'b0;
    #1;
    check("late_ack_state", dbg_state, IDLE);
    check("late_ack_req", mem_req, 0);
    check("late_ack_rdata", ReadDataM, 0);
    exp_q.delete();
    last_load = 32'h0;
    do_access(32'h10, 1'b1, SZ_WORD, 1'b0, 32'h0BAD_F00D, 1, 32'h0);

    for (int n = 0; n < 60; n++) begin
      addr = 32'h1000 + 32'($urandom_range(0, 255));
      sz   = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      do_access(addr, we, sz, 1'($urandom_range(0, 1)), $urandom,
                $urandom_range(0, 3), mem_model[addr[7:2]]);
    end

    @(posedge clk); #1;
    MemReqM = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
